// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, status flag
// positions and opcode classification helpers.
package exe_pkg;

   localparam logic [3:0] EXE_MOV = 4'b0001;
   localparam logic [3:0] EXE_MVN = 4'b1001;
   localparam logic [3:0] EXE_ADD = 4'b0010;
   localparam logic [3:0] EXE_ADC = 4'b0011;
   localparam logic [3:0] EXE_SUB = 4'b0100;
   localparam logic [3:0] EXE_SBC = 4'b0101;
   localparam logic [3:0] EXE_AND = 4'b0110;
   localparam logic [3:0] EXE_ORR = 4'b0111;
   localparam logic [3:0] EXE_EOR = 4'b1000;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Opcodes that produce a result; anything else leaves the flags alone.
   function automatic logic cmd_defined(input logic [3:0] cmd);
      case (cmd)
         EXE_MOV, EXE_MVN, EXE_ADD, EXE_ADC, EXE_SUB,
         EXE_SBC, EXE_AND, EXE_ORR, EXE_EOR: cmd_defined = 1'b1;
         default:                            cmd_defined = 1'b0;
      endcase
   endfunction

   // Opcodes whose carry/overflow outputs are meaningful.
   function automatic logic cmd_is_arith(input logic [3:0] cmd);
      case (cmd)
         EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: cmd_is_arith = 1'b1;
         default:                            cmd_is_arith = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU. Arithmetic runs through one DATA_W+1 bit adder;
// subtraction is A + ~B + carry so that C=1 means "no borrow".
// For logic/move ops c passes c_in through and v is 0; the caller decides
// whether to use them.
module exe_alu
   import exe_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        cmd,
   input  logic              c_in,
   output logic [DATA_W-1:0] res,
   output logic              n,
   output logic              z,
   output logic              c,
   output logic              v
);

   localparam int MSB = DATA_W - 1;

   logic [DATA_W:0] sum;
   logic [DATA_W:0] cin_ext;

   assign cin_ext = {{DATA_W{1'b0}}, c_in};

   // Operation select, carry and signed-overflow generation.
   always_comb begin
      sum = '0;
      res = '0;
      c   = c_in;
      v   = 1'b0;
      case (cmd)
         EXE_ADD: begin
            sum = {1'b0, a} + {1'b0, b};
            res = sum[MSB:0];
            c   = sum[DATA_W];
            v   = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
         end
         EXE_ADC: begin
            sum = {1'b0, a} + {1'b0, b} + cin_ext;
            res = sum[MSB:0];
            c   = sum[DATA_W];
            v   = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
         end
         EXE_SUB: begin
            sum = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
            res = sum[MSB:0];
            c   = sum[DATA_W];
            v   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
         end
         EXE_SBC: begin
            sum = {1'b0, a} + {1'b0, ~b} + cin_ext;
            res = sum[MSB:0];
            c   = sum[DATA_W];
            v   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
         end
         EXE_MOV: res = b;
         EXE_MVN: res = ~b;
         EXE_AND: res = a & b;
         EXE_ORR: res = a | b;
         EXE_EOR: res = a ^ b;
         default: res = '0;
      endcase
   end

   assign n = res[MSB];
   assign z = (res == '0);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, branch target, NZCV status register and the
// EXE/MEM pipeline register. Per-edge priority: reset > flush > freeze > load.
module exe_stage
   import exe_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  freeze,
   input  logic                  flush,
   input  logic                  valid_in,
   input  logic [DATA_W-1:0]     pc_in,
   input  logic [3:0]            exe_cmd,
   input  logic                  s,
   input  logic                  mem_read_en,
   input  logic                  mem_write_en,
   input  logic                  wb_en,
   input  logic                  B,
   input  logic [DATA_W-1:0]     val_rn,
   input  logic [DATA_W-1:0]     val2,
   input  logic [DATA_W-1:0]     val_rm,
   input  logic [REG_ADDR_W-1:0] dest_in,
   input  logic [23:0]           imm24,
   output logic [3:0]            status,
   output logic                  branch_taken,
   output logic [DATA_W-1:0]     branch_addr,
   output logic [DATA_W-1:0]     alu_res_q,
   output logic [DATA_W-1:0]     st_val_q,
   output logic [REG_ADDR_W-1:0] dest_q,
   output logic                  wb_en_q,
   output logic                  mem_r_q,
   output logic                  mem_w_q,
   output logic                  valid_q
);

   logic              is_mem;
   logic [3:0]        alu_cmd;
   logic [DATA_W-1:0] alu_res;
   logic              alu_n;
   logic              alu_z;
   logic              alu_c;
   logic              alu_v;
   logic              flag_upd;
   logic [3:0]        status_nxt;

   // Loads and stores always compute base + offset, whatever opcode ID sent.
   assign is_mem  = mem_read_en | mem_write_en;
   assign alu_cmd = is_mem ? EXE_ADD : exe_cmd;

   exe_alu #(
      .DATA_W(DATA_W)
   ) u_alu (
      .a    (val_rn),
      .b    (val2),
      .cmd  (alu_cmd),
      .c_in (status[FLAG_C]),
      .res  (alu_res),
      .n    (alu_n),
      .z    (alu_z),
      .c    (alu_c),
      .v    (alu_v)
   );

   assign branch_taken = B & valid_in;
   assign branch_addr  = pc_in + {{(DATA_W-26){imm24[23]}}, imm24, 2'b00};

   assign flag_upd = s & valid_in & ~is_mem & ~flush & ~freeze & cmd_defined(exe_cmd);

   // Next NZCV: N/Z follow every flag-setting op, C/V only arithmetic ones.
   always_comb begin
      status_nxt = status;
      if (flag_upd) begin
         status_nxt[FLAG_N] = alu_n;
         status_nxt[FLAG_Z] = alu_z;
         if (cmd_is_arith(exe_cmd)) begin
            status_nxt[FLAG_C] = alu_c;
            status_nxt[FLAG_V] = alu_v;
         end
      end
   end

   // EXE/MEM register and status register update.
   always_ff @(posedge clk) begin
      if (!rst) begin
         status    <= '0;
         alu_res_q <= '0;
         st_val_q  <= '0;
         dest_q    <= '0;
         wb_en_q   <= 1'b0;
         mem_r_q   <= 1'b0;
         mem_w_q   <= 1'b0;
         valid_q   <= 1'b0;
      end else if (flush) begin
         wb_en_q   <= 1'b0;
         mem_r_q   <= 1'b0;
         mem_w_q   <= 1'b0;
         valid_q   <= 1'b0;
      end else if (!freeze) begin
         status    <= status_nxt;
         alu_res_q <= alu_res;
         st_val_q  <= val_rm;
         dest_q    <= dest_in;
         wb_en_q   <= wb_en & valid_in;
         mem_r_q   <= mem_read_en & valid_in;
         mem_w_q   <= mem_write_en & valid_in;
         valid_q   <= valid_in;
      end
   end

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed scenarios followed by random traffic,
// all compared against an arithmetic reference model.
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        flush;
   logic        valid_in;
   logic [31:0] pc_in;
   logic [3:0]  exe_cmd;
   logic        s;
   logic        mem_read_en;
   logic        mem_write_en;
   logic        wb_en;
   logic        b_br;
   logic [31:0] val_rn;
   logic [31:0] val2;
   logic [31:0] val_rm;
   logic [3:0]  dest_in;
   logic [23:0] imm24;
   logic [3:0]  status;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [31:0] alu_res_q;
   logic [31:0] st_val_q;
   logic [3:0]  dest_q;
   logic        wb_en_q;
   logic        mem_r_q;
   logic        mem_w_q;
   logic        valid_q;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_alu;
   logic [31:0] m_st;
   logic [3:0]  m_dest;
   logic        m_wb;
   logic        m_mr;
   logic        m_mw;
   logic        m_valid;
   logic [3:0]  m_status;

   exe_stage dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .flush        (flush),
      .valid_in     (valid_in),
      .pc_in        (pc_in),
      .exe_cmd      (exe_cmd),
      .s            (s),
      .mem_read_en  (mem_read_en),
      .mem_write_en (mem_write_en),
      .wb_en        (wb_en),
      .B            (b_br),
      .val_rn       (val_rn),
      .val2         (val2),
      .val_rm       (val_rm),
      .dest_in      (dest_in),
      .imm24        (imm24),
      .status       (status),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .alu_res_q    (alu_res_q),
      .st_val_q     (st_val_q),
      .dest_q       (dest_q),
      .wb_en_q      (wb_en_q),
      .mem_r_q      (mem_r_q),
      .mem_w_q      (mem_w_q),
      .valid_q      (valid_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference ALU from the arithmetic definitions using 64-bit integers.
   function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, output logic [31:0] r, output logic ok,
                                   output logic arith, output logic c, output logic v);
      longint ua, ub, sa, sb, u, sg;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ok = 1'b1;
      arith = 1'b0;
      c = 1'b0;
      v = 1'b0;
      u = 0;
      sg = 0;
      r = 32'h0;
      case (cmd)
         4'b0001: r = b;
         4'b1001: r = ~b;
         4'b0110: r = a & b;
         4'b0111: r = a | b;
         4'b1000: r = a ^ b;
         4'b0010: begin arith = 1'b1; u = ua + ub;             sg = sa + sb;             c = (u > 64'hFFFFFFFF); end
         4'b0011: begin arith = 1'b1; u = ua + ub + (cin ? 1 : 0); sg = sa + sb + (cin ? 1 : 0); c = (u > 64'hFFFFFFFF); end
         4'b0100: begin arith = 1'b1; u = ua - ub;             sg = sa - sb;             c = (ua >= ub); end
         4'b0101: begin arith = 1'b1; u = ua - ub - (cin ? 0 : 1); sg = sa - sb - (cin ? 0 : 1); c = (ua >= ub + (cin ? 0 : 1)); end
         default: ok = 1'b0;
      endcase
      if (arith) begin
         r = u[31:0];
         v = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
      end
   endfunction

   // Model of one clock edge using the inputs currently applied.
   task automatic model_edge();
      logic [31:0] r;
      logic ok, ar, c, v;
      logic mem;
      mem = mem_read_en | mem_write_en;
      if (!rst) begin
         m_alu = 0; m_st = 0; m_dest = 0; m_wb = 0; m_mr = 0; m_mw = 0; m_valid = 0; m_status = 0;
      end else if (flush) begin
         m_wb = 0; m_mr = 0; m_mw = 0; m_valid = 0;
      end else if (!freeze) begin
         ref_alu(mem ? 4'b0010 : exe_cmd, val_rn, val2, m_status[1], r, ok, ar, c, v);
         m_alu   = r;
         m_st    = val_rm;
         m_dest  = dest_in;
         m_wb    = wb_en & valid_in;
         m_mr    = mem_read_en & valid_in;
         m_mw    = mem_write_en & valid_in;
         m_valid = valid_in;
         if (s && valid_in && !mem && ok) begin
            m_status[3] = r[31];
            m_status[2] = (r == 32'h0);
            if (ar) begin
               m_status[1] = c;
               m_status[0] = v;
            end
         end
      end
   endtask

   task automatic check_regs();
      chk("alu_res_q", alu_res_q, m_alu);
      chk("st_val_q",  st_val_q,  m_st);
      chk("dest_q",    {28'h0, dest_q}, {28'h0, m_dest});
      chk("wb_en_q",   {31'h0, wb_en_q}, {31'h0, m_wb});
      chk("mem_r_q",   {31'h0, mem_r_q}, {31'h0, m_mr});
      chk("mem_w_q",   {31'h0, mem_w_q}, {31'h0, m_mw});
      chk("valid_q",   {31'h0, valid_q}, {31'h0, m_valid});
      chk("status",    {28'h0, status}, {28'h0, m_status});
   endtask

   // Checks same-cycle branch outputs, then advances one edge and checks registers.
   task automatic tick();
      longint ba;
      #1;
      ba = longint'(pc_in) + longint'($signed(imm24)) * 4;
      chk("branch_taken", {31'h0, branch_taken}, {31'h0, b_br & valid_in});
      chk("branch_addr",  branch_addr, ba[31:0]);
      model_edge();
      @(posedge clk);
      #1;
      check_regs();
   endtask

   task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic sv, input logic mr, input logic mw, input logic wb,
                        input logic br, input logic vld);
      rst = 1'b1; freeze = 1'b0; flush = 1'b0;
      exe_cmd = cmd; val_rn = a; val2 = b; s = sv;
      mem_read_en = mr; mem_write_en = mw; wb_en = wb; b_br = br; valid_in = vld;
      val_rm = $urandom; dest_in = 4'($urandom_range(0, 15));
      pc_in = $urandom; imm24 = 24'($urandom);
   endtask

   function automatic logic [31:0] edge_val(input int k);
      case (k)
         0: edge_val = 32'h0000_0000;
         1: edge_val = 32'h0000_0001;
         2: edge_val = 32'h7FFF_FFFF;
         3: edge_val = 32'h8000_0000;
         default: edge_val = 32'hFFFF_FFFF;
      endcase
   endfunction

   logic [31:0] hold_alu;
   logic [3:0]  hold_st;

   initial begin
      drive(4'b0010, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      tick();
      chk("reset_alu", alu_res_q, 32'h0);
      chk("reset_status", {28'h0, status}, 32'h0);

      // ADD 5+7 with flags
      drive(4'b0010, 5, 7, 1, 0, 0, 1, 0, 1);
      tick();
      chk("t1_res", alu_res_q, 32'd12);
      chk("t1_status", {28'h0, status}, 32'h0);

      // SUB 3-5 then CMP 5,5
      drive(4'b0100, 3, 5, 1, 0, 0, 1, 0, 1);
      tick();
      chk("t2_res", alu_res_q, 32'hFFFF_FFFE);
      chk("t2_status", {28'h0, status}, 32'h8);
      drive(4'b0100, 5, 5, 1, 0, 0, 0, 0, 1);
      tick();
      chk("t2_cmp_status", {28'h0, status}, 32'h6);
      chk("t2_cmp_wb", {31'h0, wb_en_q}, 32'h0);

      // Overflow, carry preload, ADC
      drive(4'b0010, 32'h7FFF_FFFF, 1, 1, 0, 0, 1, 0, 1);
      tick();
      chk("t3_res", alu_res_q, 32'h8000_0000);
      chk("t3_status", {28'h0, status}, 32'h9);
      drive(4'b0010, 32'hFFFF_FFFF, 1, 1, 0, 0, 1, 0, 1);
      tick();
      chk("t3_carry_status", {28'h0, status}, 32'h6);
      drive(4'b0011, 0, 0, 1, 0, 0, 1, 0, 1);
      tick();
      chk("t3_adc_res", alu_res_q, 32'h1);

      // Branch backwards by two words
      drive(4'b0000, 0, 0, 0, 0, 0, 0, 1, 1);
      pc_in = 32'h100; imm24 = 24'hFFFFFE;
      #1;
      chk("t4_taken", {31'h0, branch_taken}, 32'h1);
      chk("t4_addr", branch_addr, 32'hF8);
      tick();

      // Load address, flags untouched
      hold_st = m_status;
      drive(4'b0010, 32'h40, 8, 1, 1, 0, 1, 0, 1);
      tick();
      chk("t5_addr", alu_res_q, 32'h48);
      chk("t5_mem_r", {31'h0, mem_r_q}, 32'h1);
      chk("t5_status", {28'h0, status}, {28'h0, hold_st});

      // Freeze for three cycles
      hold_alu = alu_res_q;
      hold_st  = status;
      for (int i = 0; i < 3; i++) begin
         drive(4'b0100, $urandom, $urandom, 1, 0, 0, 1, 0, 1);
         freeze = 1'b1;
         tick();
         chk("t6_frz_alu", alu_res_q, hold_alu);
         chk("t6_frz_status", {28'h0, status}, {28'h0, hold_st});
      end

      // Flush with freeze gives a bubble
      drive(4'b0010, 1, 1, 1, 0, 0, 1, 0, 1);
      freeze = 1'b1; flush = 1'b1;
      tick();
      chk("t6_flush_valid", {31'h0, valid_q}, 32'h0);
      chk("t6_flush_status", {28'h0, status}, {28'h0, hold_st});

      // Build nonzero state, then reset during a flag-setting ADD
      drive(4'b0100, 1, 2, 1, 0, 0, 1, 0, 1);
      tick();
      drive(4'b0010, 32'h7FFF_FFFF, 1, 1, 0, 0, 1, 0, 1);
      rst = 1'b0;
      tick();
      chk("t6_rst_alu", alu_res_q, 32'h0);
      chk("t6_rst_status", {28'h0, status}, 32'h0);

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         logic [31:0] a, b;
         logic mr, mw, br;
         a = ($urandom_range(0, 3) == 0) ? edge_val($urandom_range(0, 4)) : $urandom;
         b = ($urandom_range(0, 3) == 0) ? edge_val($urandom_range(0, 4)) : $urandom;
         mr = ($urandom_range(0, 7) == 0);
         mw = !mr && ($urandom_range(0, 7) == 0);
         br = !mr && !mw && ($urandom_range(0, 9) == 0);
         drive(4'($urandom_range(0, 15)), a, b, 1'($urandom), mr, mw,
               !br && !mw && ($urandom_range(0, 3) != 0), br, ($urandom_range(0, 7) != 0));
         freeze = ($urandom_range(0, 7) == 0);
         flush  = ($urandom_range(0, 9) == 0);
         rst    = ($urandom_range(0, 39) != 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
